// File: rtl/priv_trap_sequencer.sv
// -----------------------------------------------------------------------------
// priv_trap_sequencer
//
// Sequences a privileged control transfer: it captures one trap or xRET event,
// waits for the pipeline to drain, commits mcause/mepc/mtval (or signals the
// xRET commit), and then redirects fetch.
//
// State flow: IDLE -> WAIT_CLEAR -> COMMIT -> REDIRECT -> IDLE
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   fault_insn .. fault_s  exception requests, sampled only in IDLE
//   ret                 xRET retiring, sampled only in IDLE
//   timer_int, soft_int, ext_int, mie   pending interrupts and global enable
//   epc, badaddr        PC / faulting address of the capturing instruction
//   mtvec, mepc_r       trap vector and current mepc (used in REDIRECT)
//   pipe_clear          pipeline drained
//   insert_pc, priv_pc  fetch redirect pulse and target
//   intr                captured event is an interrupt (0 in IDLE)
//   busy                sequencer not in IDLE
//   csr_we, mcause_wdata, mepc_wdata, mtval_wdata   trap CSR commit pulse/data
//   ret_commit          xRET commit pulse
//   dbg_state           current FSM state for observation
//
// Handshake: there is no valid/ready pair; an event is taken when it is
// present during an IDLE cycle and every input event outside IDLE is ignored.
// pipe_clear acts as the "ready" that releases WAIT_CLEAR.
// -----------------------------------------------------------------------------
module priv_trap_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        mal_l,
  input  logic        fault_l,
  input  logic        mal_s,
  input  logic        fault_s,
  input  logic        ret,
  input  logic        timer_int,
  input  logic        soft_int,
  input  logic        ext_int,
  input  logic        mie,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_r,
  input  logic        pipe_clear,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        intr,
  output logic        busy,
  output logic        csr_we,
  output logic [31:0] mcause_wdata,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mtval_wdata,
  output logic        ret_commit,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CLEAR = 2'd1,
    COMMIT     = 2'd2,
    REDIRECT   = 2'd3
  } state_t;

  state_t      state;

  // Captured event
  logic [3:0]  code_q;
  logic        intr_q;
  logic        ret_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;

  // Capture decode (only consumed in IDLE)
  logic        any_exc;
  logic        any_int;
  logic        event_seen;
  logic [3:0]  cap_code;
  logic        cap_intr;
  logic        cap_ret;
  logic [31:0] cap_tval;

  assign any_exc    = fault_insn | mal_insn | illegal_insn | breakpoint | env |
                      mal_s | mal_l | fault_s | fault_l;
  assign any_int    = mie & (ext_int | soft_int | timer_int);
  assign event_seen = any_exc | any_int | ret;

  always_comb begin
    cap_code = 4'd0;
    cap_intr = 1'b0;
    cap_ret  = 1'b0;
    cap_tval = 32'd0;
    if (any_exc) begin
      if (fault_insn)        cap_code = 4'd1;
      else if (mal_insn)     cap_code = 4'd0;
      else if (illegal_insn) cap_code = 4'd2;
      else if (breakpoint)   cap_code = 4'd3;
      else if (env)          cap_code = 4'd11;
      else if (mal_s)        cap_code = 4'd6;
      else if (mal_l)        cap_code = 4'd4;
      else if (fault_s)      cap_code = 4'd7;
      else                   cap_code = 4'd5;
      // Only address-related exceptions report the faulting address.
      case (cap_code)
        4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: cap_tval = badaddr;
        default:                            cap_tval = 32'd0;
      endcase
    end else if (any_int) begin
      cap_intr = 1'b1;
      if (ext_int)       cap_code = 4'd11;
      else if (soft_int) cap_code = 4'd3;
      else               cap_code = 4'd7;
    end else begin
      cap_ret = ret;
    end
  end

  // FSM with registered control and CSR data outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      code_q       <= 4'd0;
      intr_q       <= 1'b0;
      ret_q        <= 1'b0;
      epc_q        <= 32'd0;
      tval_q       <= 32'd0;
      busy         <= 1'b0;
      intr         <= 1'b0;
      csr_we       <= 1'b0;
      ret_commit   <= 1'b0;
      insert_pc    <= 1'b0;
      mcause_wdata <= 32'd0;
      mepc_wdata   <= 32'd0;
      mtval_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (event_seen) begin
            state  <= WAIT_CLEAR;
            code_q <= cap_code;
            intr_q <= cap_intr;
            ret_q  <= cap_ret;
            epc_q  <= epc;
            tval_q <= cap_tval;
            busy   <= 1'b1;
            intr   <= cap_intr;
          end
        end
        WAIT_CLEAR: begin
          if (pipe_clear) begin
            state      <= COMMIT;
            csr_we     <= ~ret_q;
            ret_commit <= ret_q;
            if (!ret_q) begin
              mcause_wdata <= {intr_q, 27'd0, code_q};
              mepc_wdata   <= epc_q;
              mtval_wdata  <= tval_q;
            end
          end
        end
        COMMIT: begin
          state        <= REDIRECT;
          csr_we       <= 1'b0;
          ret_commit   <= 1'b0;
          mcause_wdata <= 32'd0;
          mepc_wdata   <= 32'd0;
          mtval_wdata  <= 32'd0;
          insert_pc    <= 1'b1;
        end
        REDIRECT: begin
          state     <= IDLE;
          insert_pc <= 1'b0;
          busy      <= 1'b0;
          intr      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Redirect target: the only outputs with a combinational path from inputs
  // (mtvec and mepc_r), and forced to 0 outside REDIRECT.
  logic [31:0] vec_base;
  assign vec_base = {mtvec[31:2], 2'b00};

  always_comb begin
    priv_pc = 32'd0;
    if (state == REDIRECT) begin
      if (ret_q)
        priv_pc = mepc_r;
      else if (intr_q && (mtvec[1:0] == 2'b01))
        priv_pc = vec_base + {26'd0, code_q, 2'b00};
      else
        priv_pc = vec_base;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_priv_trap_sequencer.sv
module tb_priv_trap_sequencer;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env;
  logic        mal_l, fault_l, mal_s, fault_s;
  logic        ret, timer_int, soft_int, ext_int, mie;
  logic [31:0] epc, badaddr, mtvec, mepc_r;
  logic        pipe_clear;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        intr, busy, csr_we, ret_commit;
  logic [31:0] mcause_wdata, mepc_wdata, mtval_wdata;
  logic [1:0]  dbg_state;

  priv_trap_sequencer dut (
    .clk(clk), .rst(rst),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env(env), .mal_l(mal_l), .fault_l(fault_l),
    .mal_s(mal_s), .fault_s(fault_s), .ret(ret),
    .timer_int(timer_int), .soft_int(soft_int), .ext_int(ext_int), .mie(mie),
    .epc(epc), .badaddr(badaddr), .mtvec(mtvec), .mepc_r(mepc_r),
    .pipe_clear(pipe_clear),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .intr(intr), .busy(busy),
    .csr_we(csr_we), .mcause_wdata(mcause_wdata), .mepc_wdata(mepc_wdata),
    .mtval_wdata(mtval_wdata), .ret_commit(ret_commit), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Priority tables: index 0 is the highest priority source.
  int exc_codes [9] = '{1, 0, 2, 3, 11, 6, 4, 7, 5};
  int int_codes [3] = '{11, 3, 7};

  logic [3:0]  m_code;
  logic        m_intr;
  logic        m_ret;
  logic [31:0] m_tval;
  logic [31:0] m_epc;

  task automatic ref_capture();
    logic [8:0] exc_vec;
    logic [2:0] int_vec;
    bit         found;
    exc_vec = {fault_l, fault_s, mal_l, mal_s, env, breakpoint, illegal_insn, mal_insn, fault_insn};
    int_vec = {timer_int, soft_int, ext_int};
    m_code = 4'd0; m_intr = 1'b0; m_ret = 1'b0; m_tval = 32'd0; found = 1'b0;
    m_epc  = epc;
    for (int i = 0; i < 9; i++)
      if (!found && exc_vec[i]) begin
        found  = 1'b1;
        m_code = 4'(exc_codes[i]);
        if (exc_codes[i] <= 1 || (exc_codes[i] >= 4 && exc_codes[i] <= 7)) m_tval = badaddr;
      end
    if (!found && mie)
      for (int i = 0; i < 3; i++)
        if (!found && int_vec[i]) begin
          found  = 1'b1;
          m_intr = 1'b1;
          m_code = 4'(int_codes[i]);
        end
    if (!found) m_ret = ret;
  endtask

  function automatic logic [31:0] ref_pc();
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (m_ret) return mepc_r;
    if (m_intr && mtvec[1:0] == 2'b01) return base + 32'(m_code) * 32'd4;
    return base;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic set_exc(input logic [8:0] v);
    {fault_l, fault_s, mal_l, mal_s, env, breakpoint, illegal_insn, mal_insn, fault_insn} = v;
  endtask

  task automatic clear_events();
    set_exc(9'd0);
    ret = 0; timer_int = 0; soft_int = 0; ext_int = 0; mie = 0;
  endtask

  task automatic noise_events();
    set_exc(9'($urandom_range(0, 511)));
    breakpoint = 1'b1;
    ret = 1'($urandom_range(0, 1));
    {timer_int, soft_int, ext_int} = 3'($urandom_range(0, 7));
    mie = 1'($urandom_range(0, 1));
    epc = $urandom; badaddr = $urandom;
  endtask

  task automatic randomize_event();
    int kind;
    epc = $urandom; badaddr = $urandom; mepc_r = $urandom;
    mtvec = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF5 : $urandom;
    clear_events();
    kind = $urandom_range(0, 3);
    case (kind)
      0: set_exc(9'($urandom_range(1, 511)));
      1: begin mie = 1; {timer_int, soft_int, ext_int} = 3'($urandom_range(1, 7)); ret = 1'($urandom_range(0, 1)); end
      2: begin ret = 1; mie = 1'($urandom_range(0, 1)); {timer_int, soft_int, ext_int} = 3'($urandom_range(0, 7)); end
      default: begin
        if ($urandom_range(0, 1) == 1) set_exc(9'(1 << $urandom_range(0, 8)));
        mie = 1'($urandom_range(0, 1));
        {timer_int, soft_int, ext_int} = 3'($urandom_range(0, 7));
        ret = 1'($urandom_range(0, 1));
      end
    endcase
    if (!((|{fault_l, fault_s, mal_l, mal_s, env, breakpoint, illegal_insn, mal_insn, fault_insn}) ||
          ret || (mie && (timer_int || soft_int || ext_int))))
      ret = 1'b1;
  endtask

  // Idle cycles: nothing may happen. Optional masked-interrupt noise.
  task automatic idle_cycles(input int n, input bit masked_noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_intr", 32'(intr), 32'd0);
      check("idle_pulses", {29'd0, csr_we, ret_commit, insert_pc}, 32'd0);
      if (masked_noise) begin
        mie = 1'b0;
        {timer_int, soft_int, ext_int} = 3'($urandom_range(0, 7));
      end
    end
  endtask

  // One full transaction. Event inputs must already be driven; called at a
  // negedge of an IDLE cycle, or of a REDIRECT cycle when prev_redirect=1.
  // Returns at the negedge of the REDIRECT cycle with event inputs cleared.
  task automatic run_txn(input bit prev_redirect, input int delay, input bit noise);
    logic [31:0] e_mcause;
    ref_capture();
    exp_q.push_back({m_intr, 27'd0, m_code});
    if (prev_redirect) begin
      @(negedge clk);
      check("b2b_idle_busy", 32'(busy), 32'd0);
      check("b2b_idle_insert", 32'(insert_pc), 32'd0);
    end
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    check("wait_intr", 32'(intr), 32'(m_intr));
    check("wait_pulses", {29'd0, csr_we, ret_commit, insert_pc}, 32'd0);
    clear_events();
    if (noise) noise_events();
    pipe_clear = (delay == 0);
    for (int i = 1; i <= delay; i++) begin
      @(negedge clk);
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_pulses", {29'd0, csr_we, ret_commit, insert_pc}, 32'd0);
      if (noise) noise_events();
      pipe_clear = (i == delay);
    end
    @(negedge clk);
    clear_events();
    pipe_clear = 1'($urandom_range(0, 1));
    e_mcause = exp_q.pop_front();
    check("commit_csr_we", 32'(csr_we), 32'(!m_ret));
    check("commit_ret", 32'(ret_commit), 32'(m_ret));
    check("commit_insert", 32'(insert_pc), 32'd0);
    check("commit_busy", 32'(busy), 32'd1);
    check("commit_intr", 32'(intr), 32'(m_intr));
    check("commit_mcause", mcause_wdata, m_ret ? 32'd0 : e_mcause);
    check("commit_mepc", mepc_wdata, m_ret ? 32'd0 : m_epc);
    check("commit_mtval", mtval_wdata, m_ret ? 32'd0 : m_tval);
    if (noise) mepc_r = $urandom;
    @(negedge clk);
    check("redir_insert", 32'(insert_pc), 32'd1);
    check("redir_priv_pc", priv_pc, ref_pc());
    check("redir_pulses", {30'd0, csr_we, ret_commit}, 32'd0);
    check("redir_busy", 32'(busy), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_intr"}, 32'(intr), 32'd0);
    check({tag, "_pulses"}, {29'd0, csr_we, ret_commit, insert_pc}, 32'd0);
    check({tag, "_priv_pc"}, priv_pc, 32'd0);
    check({tag, "_mcause"}, mcause_wdata, 32'd0);
    check({tag, "_mepc"}, mepc_wdata, 32'd0);
    check({tag, "_mtval"}, mtval_wdata, 32'd0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    clear_events();
    epc = 0; badaddr = 0; mtvec = 0; mepc_r = 0; pipe_clear = 0;
    rst = 1'b1;
    @(negedge clk);
    set_exc(9'h1FF);  // events during reset must be ignored
    @(negedge clk);
    check_all_zero("reset");
    clear_events();
    rst = 1'b0;
    idle_cycles(2, 0);

    // Exception priority: illegal_insn + mal_l
    set_exc(9'd0); illegal_insn = 1; mal_l = 1;
    epc = 32'h200; badaddr = 32'h1003; mtvec = 32'h100;
    run_txn(0, 0, 0);
    idle_cycles(1, 0);

    // Vectored interrupt: timer + ext, mtvec mode 1
    mie = 1; timer_int = 1; ext_int = 1; mtvec = 32'h101; epc = 32'h300;
    run_txn(0, 0, 0);
    idle_cycles(1, 0);

    // Masked interrupt for 10 cycles
    mie = 0; soft_int = 1;
    idle_cycles(10, 0);
    clear_events();

    // ret with concurrent fault_s, then ret alone
    ret = 1; fault_s = 1; badaddr = 32'h44; epc = 32'h500; mtvec = 32'h100;
    run_txn(0, 0, 0);
    idle_cycles(1, 0);
    ret = 1; mepc_r = 32'h80;
    run_txn(0, 0, 0);
    idle_cycles(1, 0);

    // Drain wait with breakpoint pulsed during the wait
    illegal_insn = 1; epc = 32'h600; mtvec = 32'h140;
    run_txn(0, 5, 1);
    idle_cycles(1, 0);

    // Reset in WAIT_CLEAR
    mal_insn = 1; badaddr = 32'h77; epc = 32'h700; pipe_clear = 0;
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset");
    clear_events(); pipe_clear = 1;
    @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;
    idle_cycles(5, 0);
    // Capture on the first edge after release
    rst = 1'b1;
    @(negedge clk);
    env = 1; epc = 32'h800;
    rst = 1'b0;
    run_txn(0, 1, 0);

    // Randomized transactions, some back to back
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        randomize_event();
        run_txn(1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end else begin
        idle_cycles($urandom_range(1, 3), 1);
        randomize_event();
        run_txn(0, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end
    end
    idle_cycles(2, 0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
